// File: rtl/anti_theft_controller.sv
// Anti-theft sequencer: arm/disarm FSM with entry/alarm/re-arm timers,
// siren and status decode, and a fuel pump enable latched by brake+hidden.
module anti_theft_controller #(
  parameter int unsigned T_ARM_DELAY       = 6,
  parameter int unsigned T_DRIVER_DELAY    = 8,
  parameter int unsigned T_PASSENGER_DELAY = 15,
  parameter int unsigned T_ALARM_ON        = 10,
  parameter int unsigned CNT_W             = 8
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       ignition,
  input  logic       brake,
  input  logic       hidden,
  input  logic       door_driver,
  input  logic       door_pass,
  output logic       fuel_pump_power,
  output logic       siren,
  output logic       status_led,
  output logic [2:0] state
);

  typedef enum logic [2:0] {
    ARMED      = 3'd0,
    TRIGGER    = 3'd1,
    SOUND      = 3'd2,
    DISARMED   = 3'd3,
    WAIT_OPEN  = 3'd4,
    WAIT_CLOSE = 3'd5,
    ARM_COUNT  = 3'd6
  } state_t;

  localparam logic [CNT_W-1:0] LD_ARM    = CNT_W'(T_ARM_DELAY);
  localparam logic [CNT_W-1:0] LD_DRIVER = CNT_W'(T_DRIVER_DELAY);
  localparam logic [CNT_W-1:0] LD_PASS   = CNT_W'(T_PASSENGER_DELAY);
  localparam logic [CNT_W-1:0] LD_ALARM  = CNT_W'(T_ALARM_ON);
  localparam logic [CNT_W-1:0] ONE       = CNT_W'(1);

  state_t           state_reg;
  logic [CNT_W-1:0] cnt_reg;
  logic             pump_reg;
  logic             any_door;
  logic             expired;

  assign any_door = door_driver | door_pass;
  // Exit at 1 (or a stray 0) so the counter can never wrap.
  assign expired  = (cnt_reg <= ONE);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_reg <= ARMED;
      cnt_reg   <= '0;
    end else if (ignition && state_reg != DISARMED) begin
      state_reg <= DISARMED;
      cnt_reg   <= '0;
    end else begin
      case (state_reg)
        ARMED: begin
          if (door_driver) begin
            state_reg <= TRIGGER;
            cnt_reg   <= LD_DRIVER;
          end else if (door_pass) begin
            state_reg <= TRIGGER;
            cnt_reg   <= LD_PASS;
          end
        end
        TRIGGER: begin
          if (expired) begin
            state_reg <= SOUND;
            cnt_reg   <= LD_ALARM;
          end else begin
            cnt_reg <= cnt_reg - ONE;
          end
        end
        SOUND: begin
          if (any_door) begin
            cnt_reg <= LD_ALARM;
          end else if (expired) begin
            state_reg <= ARMED;
            cnt_reg   <= '0;
          end else begin
            cnt_reg <= cnt_reg - ONE;
          end
        end
        DISARMED: begin
          if (!ignition) state_reg <= WAIT_OPEN;
        end
        WAIT_OPEN: begin
          if (door_driver) state_reg <= WAIT_CLOSE;
        end
        WAIT_CLOSE: begin
          if (!any_door) begin
            state_reg <= ARM_COUNT;
            cnt_reg   <= LD_ARM;
          end
        end
        ARM_COUNT: begin
          if (any_door) begin
            state_reg <= WAIT_CLOSE;
            cnt_reg   <= '0;
          end else if (expired) begin
            state_reg <= ARMED;
            cnt_reg   <= '0;
          end else begin
            cnt_reg <= cnt_reg - ONE;
          end
        end
        default: begin
          state_reg <= ARMED;
          cnt_reg   <= '0;
        end
      endcase
    end
  end

  // Pump holds once unlocked; only ignition off or leaving DISARMED clears it.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      pump_reg <= 1'b0;
    end else if (state_reg == DISARMED && ignition && brake && hidden) begin
      pump_reg <= 1'b1;
    end else if (!ignition || state_reg != DISARMED) begin
      pump_reg <= 1'b0;
    end
  end

  assign fuel_pump_power = pump_reg;
  assign siren           = (state_reg == SOUND);
  assign status_led      = (state_reg == ARMED) || (state_reg == TRIGGER) ||
                           (state_reg == SOUND);
  assign state           = state_reg;

endmodule

// File: tb/tb_anti_theft_controller.sv
// Directed bench for anti_theft_controller: walks alarm, disarm, pump unlock,
// re-arm and async reset scenarios against hand-computed expectations.
module tb_anti_theft_controller;

  logic       clock = 1'b0;
  logic       reset_n;
  logic       ignition, brake, hidden, door_driver, door_pass;
  logic       fuel_pump_power, siren, status_led;
  logic [2:0] state;

  int vec_count = 0;
  int err_count = 0;

  anti_theft_controller dut (
    .clock           (clock),
    .reset_n         (reset_n),
    .ignition        (ignition),
    .brake           (brake),
    .hidden          (hidden),
    .door_driver     (door_driver),
    .door_pass       (door_pass),
    .fuel_pump_power (fuel_pump_power),
    .siren           (siren),
    .status_led      (status_led),
    .state           (state)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    vec_count++;
    if (got !== exp) begin
      err_count++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  // Advance n edges and settle 1 time unit past the last one.
  task automatic step(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  initial begin
    reset_n = 1'b0; ignition = 0; brake = 0; hidden = 0;
    door_driver = 0; door_pass = 0;
    #3;
    check("rst_state", 8'(state), 8'd0);
    check("rst_siren", 8'(siren), 8'd0);
    check("rst_led", 8'(status_led), 8'd1);
    check("rst_pump", 8'(fuel_pump_power), 8'd0);
    step(2);
    reset_n = 1'b1;
    step(1);
    check("armed_idle", 8'(state), 8'd0);

    // Driver entry: 8 cycles TRIGGER, 10 cycles SOUND, back to ARMED.
    door_driver = 1; step(1); door_driver = 0;
    for (int i = 0; i < 8; i++) begin
      check("drv_trigger", 8'(state), 8'd1);
      check("drv_trig_siren", 8'(siren), 8'd0);
      step(1);
    end
    for (int i = 0; i < 10; i++) begin
      check("drv_sound", 8'(state), 8'd2);
      check("drv_siren", 8'(siren), 8'd1);
      step(1);
    end
    check("drv_rearmed", 8'(state), 8'd0);
    check("drv_siren_off", 8'(siren), 8'd0);

    // Both doors together: driver delay (8) wins over passenger (15).
    door_driver = 1; door_pass = 1; step(1); door_driver = 0; door_pass = 0;
    step(7);
    check("both_trig_last", 8'(state), 8'd1);
    step(1);
    check("both_sound", 8'(state), 8'd2);
    step(2);

    // Ignition overrides an active alarm.
    ignition = 1; step(1);
    check("ign_from_sound", 8'(state), 8'd3);
    check("ign_led", 8'(status_led), 8'd0);
    ignition = 0; step(1);
    check("wait_open", 8'(state), 8'd4);
    door_driver = 1; step(1); door_driver = 0; step(1);
    step(6);
    check("back_armed", 8'(state), 8'd0);

    // Passenger entry, disarmed 5 cycles later.
    door_pass = 1; step(1); door_pass = 0;
    for (int i = 0; i < 5; i++) begin
      check("pass_trigger", 8'(state), 8'd1);
      check("pass_no_siren", 8'(siren), 8'd0);
      if (i < 4) step(1);
    end
    ignition = 1; step(1);
    check("pass_disarm", 8'(state), 8'd3);
    check("pass_led", 8'(status_led), 8'd0);
    check("pass_siren", 8'(siren), 8'd0);

    // Fuel pump: single switches do nothing, both together latch.
    brake = 1; step(2);
    check("pump_brake_only", 8'(fuel_pump_power), 8'd0);
    brake = 0; hidden = 1; step(2);
    check("pump_hidden_only", 8'(fuel_pump_power), 8'd0);
    hidden = 0; step(1);
    brake = 1; hidden = 1; step(1); brake = 0; hidden = 0;
    check("pump_set", 8'(fuel_pump_power), 8'd1);
    step(3);
    check("pump_hold", 8'(fuel_pump_power), 8'd1);
    ignition = 0; step(1);
    check("pump_clear", 8'(fuel_pump_power), 8'd0);
    check("rearm_wait_open", 8'(state), 8'd4);

    // Re-arm with a re-open at cycle 3 of ARM_COUNT.
    door_driver = 1; step(1);
    check("rearm_wait_close", 8'(state), 8'd5);
    door_driver = 0; step(1);
    for (int i = 0; i < 3; i++) begin
      check("rearm_count_a", 8'(state), 8'd6);
      if (i < 2) step(1);
    end
    door_driver = 1; step(1);
    check("rearm_reopen", 8'(state), 8'd5);
    door_driver = 0; step(1);
    for (int i = 0; i < 6; i++) begin
      check("rearm_count_b", 8'(state), 8'd6);
      step(1);
    end
    check("rearm_armed", 8'(state), 8'd0);
    check("rearm_led", 8'(status_led), 8'd1);

    // Passenger entry to SOUND, hold alarm with open door for 20 cycles.
    door_pass = 1; step(1); door_pass = 0;
    step(14);
    check("hold_trig_last", 8'(state), 8'd1);
    step(1);
    check("hold_sound", 8'(state), 8'd2);
    door_pass = 1;
    for (int i = 0; i < 20; i++) begin
      step(1);
      check("hold_open_siren", 8'(siren), 8'd1);
    end
    door_pass = 0;
    for (int i = 0; i < 10; i++) begin
      check("hold_tail", 8'(state), 8'd2);
      step(1);
    end
    check("hold_done", 8'(state), 8'd0);
    check("hold_siren_off", 8'(siren), 8'd0);

    // Async reset mid-SOUND clears without a clock edge.
    door_driver = 1; step(1); door_driver = 0;
    step(8);
    check("ar_sound", 8'(state), 8'd2);
    step(3);
    #1 reset_n = 1'b0;
    #1;
    check("ar_state", 8'(state), 8'd0);
    check("ar_siren", 8'(siren), 8'd0);
    check("ar_led", 8'(status_led), 8'd1);
    check("ar_pump", 8'(fuel_pump_power), 8'd0);
    step(1);
    reset_n = 1'b1;
    step(12);
    check("ar_no_resume", 8'(state), 8'd0);
    check("ar_no_siren", 8'(siren), 8'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vec_count, err_count);
    $finish;
  end

endmodule

// File: doc/anti_theft_controller.md
# anti_theft_controller

Top-level sequencer for the anti-theft system: tracks vehicle arm/disarm state from ignition and door switches, times the entry and alarm windows, drives the siren and status LED, and gates the fuel pump. The pump is enabled only while the system is disarmed, ignition is on, and the brake plus hidden switch have been pressed together. The block replaces the free-standing fuel pump gate with a controller that owns both the arming sequence and the pump enable.

## Interface
- T_ARM_DELAY, 6: cycles all doors must stay closed before re-arming.
- T_DRIVER_DELAY, 8: entry window after driver door opens while armed.
- T_PASSENGER_DELAY, 15: entry window after passenger door opens while armed.
- T_ALARM_ON, 10: siren duration with all doors closed.
- CNT_W, 8: countdown width. All T_* values must be in 1..2^CNT_W-1.

- clock  in  1  system clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- ignition  in  1  1 = ignition on.
- brake  in  1  1 = brake pedal pressed.
- hidden  in  1  1 = hidden switch pressed.
- door_driver  in  1  1 = driver door open.
- door_pass  in  1  1 = passenger door open.
- fuel_pump_power  out  1  registered pump enable.
- siren  out  1  alarm sounding.
- status_led  out  1  1 while the system is armed or alarming.
- state  out  3  current FSM state, encoding below.

## Operation
- States and encodings: ARMED=0, TRIGGER=1, SOUND=2, DISARMED=3, WAIT_OPEN=4, WAIT_CLOSE=5, ARM_COUNT=6. Codes 7 and any illegal value go to ARMED on the next edge.
- **Countdown rule.** On entering a timed state the counter loads N. It decrements on each edge spent in the state. When the counter is 1 at an edge, the state exits, so the block spends exactly N cycles in the state.
- **Priority.** ignition=1 moves every state except DISARMED to DISARMED. This takes priority over door and timer events.
- ARMED: if door_driver=1, go to TRIGGER and load T_DRIVER_DELAY. Otherwise, if door_pass=1, go to TRIGGER and load T_PASSENGER_DELAY. The driver door wins if both doors open together.
- TRIGGER: count down; on expiry go to SOUND and load T_ALARM_ON. Door activity in TRIGGER is ignored.
- SOUND: if any door is open, reload T_ALARM_ON and stay. If doors are closed, count down; on expiry go to ARMED.
- DISARMED: if ignition=0, go to WAIT_OPEN.
- WAIT_OPEN: if door_driver=1, go to WAIT_CLOSE.
- WAIT_CLOSE: if both doors are closed, go to ARM_COUNT and load T_ARM_DELAY.
- ARM_COUNT: if any door opens, go to WAIT_CLOSE. Otherwise count down; on expiry go to ARMED.
- Output decode:
  - siren = (state==SOUND).
  - status_led = state in {ARMED, TRIGGER, SOUND}.
  - Both are Moore outputs decoded from the registered state.
- **Fuel pump flop.**
  - Set at an edge where state==DISARMED and ignition, brake and hidden are all 1.
  - Cleared at any edge where ignition=0 or state!=DISARMED.
  - Otherwise it holds. Once set, the pump stays on after brake and hidden are released.

## Timing
- Reset (asynchronous, immediate) gives: state=ARMED, counter=0, fuel_pump_power=0, siren=0, status_led=1.
- Reset mid-alarm or mid-count aborts immediately; no timer value is preserved.
- Input to state latency is 1 edge. Moore outputs follow state in the same cycle.
- fuel_pump_power is registered, so it rises 1 edge after the set condition is sampled and falls 1 edge after ignition=0 is sampled.
- Inputs are synchronous to clock. Debounce and synchronisation happen upstream.
- Counter arithmetic is unsigned CNT_W bits. It never wraps, because exit happens at 1 and it is reloaded on every entry.

## Test plan
- **Driver entry to alarm.** After reset, pulse door_driver=1 for 1 cycle. Expected: state=1 for 8 cycles, then state=2 with siren=1 for 10 cycles, then state=0 and siren=0.
- **Passenger entry with disarm.** Pulse door_pass=1 while ARMED, then raise ignition 5 cycles later. Expected: state=3 on the next edge, siren never asserts, status_led=0.
- **Alarm hold by open door.** In SOUND, hold door_pass=1 for 20 cycles, then close it. Expected: siren stays 1 throughout, then lasts exactly 10 more cycles before ARMED.
- **Fuel pump unlock.**
  - In DISARMED with ignition=1, assert brake=1 and hidden=1 together for 1 cycle. Expected: fuel_pump_power=1 one edge later, held after release.
  - Then drop ignition. Expected: pump=0 after 1 edge.
  - Brake alone or hidden alone leaves the pump at 0.
- **Re-arm sequence.**
  - From DISARMED: ignition=0, then door_driver 1→0. Expected: state 4→5→6, then ARMED after 6 closed cycles.
  - Re-open the door at cycle 3 of ARM_COUNT. Expected: return to WAIT_CLOSE, and the full 6-cycle count restarts on close.
- **Asynchronous reset mid-SOUND with pump logic idle.** Expected: siren, fuel_pump_power and counter clear without a clock edge, state=0 and status_led=1.
